// File: rtl/levinson_control_param.sv
// levinson_control_param
// Control FSM for the Levinson-Durbin recursion of the LPC datapath.
// Generates one-hot bank selects for r / a / temp and the mux and load
// strobes for q, k and e. The prediction order is a parameter, the divider
// is reached through a start/done handshake, and the block itself has a
// start/busy/done handshake so it can be rerun without a reset.
//
// Optional feature (compile-time macro LEVINSON_STAB_CHECK_EN):
//   adds k_unstable_i / error_o. An unstable reflection coefficient seen
//   with div_done aborts the run straight to DONE without loading k, and
//   raises a sticky error that the next accepted start clears.
//
// Parameter constraints: 2 <= ORDER <= 15, 2**IW > ORDER.

module levinson_control_param #(
    parameter int ORDER = 10,
    parameter int IW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IW-1:0]    iter_o,
    output logic [ORDER:0]   r_rsel_o,
    output logic [ORDER-1:0] a_rsel_o,
    output logic [ORDER-1:0] a_wsel_o,
    output logic [ORDER-2:0] temp_sel_o,
    output logic             out_sel_o,
    output logic             e_sel_o,
    output logic             q_sel_o,
    output logic             q_load_o,
    output logic             k_load_o,
    output logic             e_load_o,
    output logic             div_start_o,
    input  logic             div_done_i
`ifdef LEVINSON_STAB_CHECK_EN
    ,
    input  logic             k_unstable_i,
    output logic             error_o
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_Q_INIT,
        S_Q_ACC,
        S_DIV_REQ,
        S_DIV_WAIT,
        S_SAVE,
        S_UPD_E,
        S_UPD_A,
        S_NEXT,
        S_DONE
    } state_t;

    // Bit-0 seeds for the one-hot selects; each select is a seed shifted by an index.
    localparam logic [ORDER:0]   R_ONE = (ORDER+1)'(1);
    localparam logic [ORDER-1:0] A_ONE = ORDER'(1);
    localparam logic [ORDER-2:0] T_ONE = (ORDER-1)'(1);
    localparam logic [IW-1:0]    I_ONE = IW'(1);
    localparam logic [IW-1:0]    I_LAST = IW'(ORDER - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;   // outer index
    logic [IW-1:0] j_q, j_d;   // inner index (counts down inside each phase)
    logic          k_ok;       // reflection coefficient may be loaded

`ifdef LEVINSON_STAB_CHECK_EN
    logic error_q;

    assign k_ok    = ~k_unstable_i;
    assign error_o = error_q;

    // Sticky stability flag: set on an unstable k, cleared by the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (state_q == S_IDLE && start_i) begin
            error_q <= 1'b0;
        end else if (state_q == S_DIV_WAIT && div_done_i && k_unstable_i) begin
            error_q <= 1'b1;
        end
    end
`else
    assign k_ok = 1'b1;
`endif

    assign iter_o = i_q;

    // State and index registers; synchronous reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Next-state, index updates and Moore-decoded selects/strobes (k_load also needs div_done).
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        r_rsel_o    = '0;
        a_rsel_o    = '0;
        a_wsel_o    = '0;
        temp_sel_o  = '0;
        out_sel_o   = 1'b0;
        e_sel_o     = 1'b0;
        q_sel_o     = 1'b0;
        q_load_o    = 1'b0;
        k_load_o    = 1'b0;
        e_load_o    = 1'b0;
        div_start_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = S_INIT;
            end

            // e <= r[0]; restart the outer loop at i = 0.
            S_INIT: begin
                r_rsel_o = R_ONE;
                e_load_o = 1'b1;
                i_d      = '0;
                state_d  = S_Q_INIT;
            end

            // q <= r[i+1]; the accumulation phase is skipped on the first iteration.
            S_Q_INIT: begin
                r_rsel_o = R_ONE << (i_q + I_ONE);
                q_load_o = 1'b1;
                j_d      = i_q;
                state_d  = (i_q == '0) ? S_DIV_REQ : S_Q_ACC;
            end

            // q accumulates r[j] * a[i-j] for j = i down to 1.
            S_Q_ACC: begin
                r_rsel_o = R_ONE << j_q;
                a_rsel_o = A_ONE << (i_q - j_q);
                q_sel_o  = 1'b1;
                q_load_o = 1'b1;
                j_d      = j_q - I_ONE;
                if (j_q == I_ONE) state_d = S_DIV_REQ;
            end

            S_DIV_REQ: begin
                div_start_o = 1'b1;
                state_d     = S_DIV_WAIT;
            end

            // Wait for the divider; k is captured in the div_done cycle.
            S_DIV_WAIT: begin
                if (div_done_i) begin
                    if (k_ok) begin
                        k_load_o = 1'b1;
                        j_d      = i_q;
                        state_d  = (i_q == '0) ? S_UPD_E : S_SAVE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            // Copy the current a[] into the temp bank before it is overwritten.
            S_SAVE: begin
                a_rsel_o   = A_ONE << (j_q - I_ONE);
                temp_sel_o = T_ONE << (i_q - j_q);
                j_d        = j_q - I_ONE;
                if (j_q == I_ONE) state_d = S_UPD_E;
            end

            // a[i] <= k and e <= e*(1-k^2) in the same cycle.
            S_UPD_E: begin
                a_wsel_o = A_ONE << i_q;
                e_sel_o  = 1'b1;
                e_load_o = 1'b1;
                j_d      = i_q - I_ONE;
                state_d  = (i_q == '0) ? S_NEXT : S_UPD_A;
            end

            // a[j] <= a[j] - k*temp[j] for j = i-1 down to 0.
            S_UPD_A: begin
                a_rsel_o   = A_ONE << j_q;
                a_wsel_o   = A_ONE << j_q;
                temp_sel_o = T_ONE << j_q;
                out_sel_o  = 1'b1;
                j_d        = j_q - I_ONE;
                if (j_q == '0) state_d = S_NEXT;
            end

            S_NEXT: begin
                if (i_q == I_LAST) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + I_ONE;
                    state_d = S_Q_INIT;
                end
            end

            S_DONE: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_levinson_control_param.sv
// tb_levinson_control_param
// Directed bench for levinson_control_param. Three instances (ORDER = 2, 4
// and 10) share clock and reset; each has a small divider responder that
// raises div_done a programmable number of cycles after div_start.
// Cycle numbers below count from the cycle in which start is high (cycle 0).
// With LEVINSON_STAB_CHECK_EN defined the stability abort is also exercised.

module tb_levinson_control_param;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int   nvec = 0;
    int   nerr = 0;
    int   c;
    int   cnt_a;
    int   cnt_b;
    logic flag;
    logic slow4 = 1'b0;

    // ORDER = 2 instance
    logic       st2 = 1'b0;
    logic       busy2, done2, os2, es2, qs2, ql2, kl2, el2, ds2, dd2;
    logic [3:0] iter2;
    logic [2:0] rr2;
    logic [1:0] ar2, aw2;
    logic [0:0] ts2;

    // ORDER = 4 instance
    logic       st4 = 1'b0;
    logic       busy4, done4, os4, es4, qs4, ql4, kl4, el4, ds4, dd4;
    logic [3:0] iter4;
    logic [4:0] rr4;
    logic [3:0] ar4, aw4;
    logic [2:0] ts4;

    // ORDER = 10 instance
    logic       st10 = 1'b0;
    logic       busy10, done10, os10, es10, qs10, ql10, kl10, el10, ds10, dd10;
    logic [3:0] iter10;
    logic [10:0] rr10;
    logic [9:0]  ar10, aw10;
    logic [8:0]  ts10;

`ifdef LEVINSON_STAB_CHECK_EN
    logic kun4 = 1'b0;
    logic err2, err4, err10;
`endif

    logic [63:0] all2, all4, all10, stb4;
    assign all2  = 64'({busy2, done2, iter2, rr2, ar2, aw2, ts2, os2, es2, qs2, ql2, kl2, el2, ds2});
    assign all4  = 64'({busy4, done4, iter4, rr4, ar4, aw4, ts4, os4, es4, qs4, ql4, kl4, el4, ds4});
    assign all10 = 64'({busy10, done10, iter10, rr10, ar10, aw10, ts10, os10, es10, qs10, ql10, kl10, el10, ds10});
    assign stb4  = 64'({done4, rr4, ar4, aw4, ts4, os4, es4, qs4, ql4, kl4, el4, ds4});

    levinson_control_param #(.ORDER(2), .IW(4)) u2 (
        .clk(clk), .reset(reset), .start_i(st2), .busy_o(busy2), .done_o(done2),
        .iter_o(iter2), .r_rsel_o(rr2), .a_rsel_o(ar2), .a_wsel_o(aw2), .temp_sel_o(ts2),
        .out_sel_o(os2), .e_sel_o(es2), .q_sel_o(qs2), .q_load_o(ql2), .k_load_o(kl2),
        .e_load_o(el2), .div_start_o(ds2), .div_done_i(dd2)
`ifdef LEVINSON_STAB_CHECK_EN
        , .k_unstable_i(1'b0), .error_o(err2)
`endif
    );

    levinson_control_param #(.ORDER(4), .IW(4)) u4 (
        .clk(clk), .reset(reset), .start_i(st4), .busy_o(busy4), .done_o(done4),
        .iter_o(iter4), .r_rsel_o(rr4), .a_rsel_o(ar4), .a_wsel_o(aw4), .temp_sel_o(ts4),
        .out_sel_o(os4), .e_sel_o(es4), .q_sel_o(qs4), .q_load_o(ql4), .k_load_o(kl4),
        .e_load_o(el4), .div_start_o(ds4), .div_done_i(dd4)
`ifdef LEVINSON_STAB_CHECK_EN
        , .k_unstable_i(kun4), .error_o(err4)
`endif
    );

    levinson_control_param #(.ORDER(10), .IW(4)) u10 (
        .clk(clk), .reset(reset), .start_i(st10), .busy_o(busy10), .done_o(done10),
        .iter_o(iter10), .r_rsel_o(rr10), .a_rsel_o(ar10), .a_wsel_o(aw10), .temp_sel_o(ts10),
        .out_sel_o(os10), .e_sel_o(es10), .q_sel_o(qs10), .q_load_o(ql10), .k_load_o(kl10),
        .e_load_o(el10), .div_start_o(ds10), .div_done_i(dd10)
`ifdef LEVINSON_STAB_CHECK_EN
        , .k_unstable_i(1'b0), .error_o(err10)
`endif
    );

    // Divider responders: div_done is high in the L-th cycle after div_start.
    int wc2, wc4, wc10;
    always @(posedge clk) begin
        if (reset) begin
            wc2  <= 0;
            wc4  <= 0;
            wc10 <= 0;
        end else begin
            if (ds2) wc2 <= 1;
            else if (wc2 != 0) wc2 <= wc2 - 1;
            if (ds4) wc4 <= (slow4 && iter4 == 4'd2) ? 7 : 1;
            else if (wc4 != 0) wc4 <= wc4 - 1;
            if (ds10) wc10 <= 1;
            else if (wc10 != 0) wc10 <= wc10 - 1;
        end
    end
    assign dd2  = (wc2 == 1);
    assign dd4  = (wc4 == 1);
    assign dd10 = (wc10 == 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) tick();
        chk("rst_u2", all2, 64'd0);
        chk("rst_u4", all4, 64'd0);
        chk("rst_u10", all10, 64'd0);
`ifdef LEVINSON_STAB_CHECK_EN
        chk("rst_err", 64'({err2, err4, err10}), 64'd0);
`endif
        reset = 1'b0;
        tick();

        // ---- ORDER=2, L=1; a start pulse while busy must be ignored ----
        st2 = 1'b1;
        tick(); c = 1; st2 = 1'b0;
        chk("t1_init", 64'({busy2, el2, es2, rr2}), 64'b1_1_0_001);
        cnt_a = 0; cnt_b = 0; flag = 1'b1;
        while (!done2 && c < 100) begin
            if (!busy2) flag = 1'b0;
            if (ds2) cnt_a++;
            if (kl2) cnt_b++;
            st2 = (c == 5);
            tick(); c++;
        end
        st2 = 1'b0;
        chk("t1_done_cycle", 64'(c), 64'd15);
        chk("t1_busy_1_14", 64'(flag), 64'd1);
        chk("t1_done_busy", 64'(busy2), 64'd0);
        chk("t1_div_starts", 64'(cnt_a), 64'd2);
        chk("t1_k_loads", 64'(cnt_b), 64'd2);
        tick(); tick();
        chk("t1_no_rerun", 64'({busy2, done2}), 64'd0);

        // ---- ORDER=10, L=1; inner sequences of iteration i=3 ----
        st10 = 1'b1;
        tick(); c = 1; st10 = 1'b0;
        while (!done10 && c < 400) begin
            if (c == 26) chk("t2_qinit", 64'({iter10, rr10}), {49'd0, 4'd3, 11'b000_0001_0000});
            if (c >= 27 && c <= 29) begin
                chk("t2_qacc_r", 64'(rr10), 64'd1 << (30 - c));
                chk("t2_qacc_a", 64'(ar10), 64'd1 << (c - 27));
            end
            if (c == 31) chk("t2_kload", 64'({kl10, dd10}), 64'b11);
            if (c >= 32 && c <= 34) begin
                chk("t2_save_t", 64'(ts10), 64'd1 << (c - 32));
                chk("t2_save_a", 64'(ar10), 64'd1 << (34 - c));
            end
            if (c == 35) chk("t2_upde", 64'({aw10, es10, el10}), {52'd0, 10'b00_0000_1000, 2'b11});
            if (c >= 36 && c <= 38) chk("t2_upda_w", 64'({aw10, os10}), (64'd1 << (39 - c)) | 64'd1);
            if (c == 39) chk("t2_next_iter", 64'(iter10), 64'd3);
            tick(); c++;
        end
        chk("t2_done_cycle", 64'(c), 64'd187);

        // ---- ORDER=4, divider 7 cycles on iteration 2 ----
        slow4 = 1'b1;
        st4 = 1'b1;
        tick(); c = 1; st4 = 1'b0;
        cnt_a = 0; flag = 1'b1;
        while (!done4 && c < 200) begin
            if (kl4) begin
                cnt_a++;
                if (!dd4) flag = 1'b0;
            end
            if (c >= 19 && c <= 24) chk("t3_wait_quiet", stb4, 64'd0);
            if (c == 22) chk("t3_wait_busy", 64'({busy4, iter4}), 64'b1_0010);
            if (c == 25) chk("t3_kload_done", 64'({kl4, dd4}), 64'b11);
            tick(); c++;
        end
        slow4 = 1'b0;
        chk("t3_done_cycle", 64'(c), 64'd46);
        chk("t3_k_loads", 64'(cnt_a), 64'd4);
        chk("t3_kload_only_done", 64'(flag), 64'd1);
        tick();

        // ---- ORDER=4, reset in SAVE of i=2, then a clean run ----
        st4 = 1'b1;
        tick(); c = 1; st4 = 1'b0;
        while (c < 20) begin
            tick(); c++;
        end
        chk("t4_in_save", 64'({iter4, ts4}), {57'd0, 4'd2, 3'b001});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_abort", all4, 64'd0);
        tick();
        chk("t4_idle", all4, 64'd0);
        st4 = 1'b1;
        tick(); c = 1; st4 = 1'b0;
        while (!done4 && c < 200) begin
            tick(); c++;
        end
        chk("t4_done_cycle", 64'(c), 64'd40);
        tick();

        // ---- ORDER=2, start held high: back-to-back runs ----
        st2 = 1'b1;
        tick(); c = 1;
        while (!done2 && c < 100) begin
            tick(); c++;
        end
        chk("t5_done1", 64'(c), 64'd15);
        tick(); c++;
        chk("t5_idle_gap", 64'({busy2, done2, el2}), 64'd0);
        tick(); c++;
        chk("t5_reinit", 64'({busy2, el2, rr2}), 64'b1_1_001);
        while (!done2 && c < 100) begin
            tick(); c++;
        end
        chk("t5_done2", 64'(c), 64'd31);
        st2 = 1'b0;
        tick(); tick();
        chk("t5_stop", 64'({busy2, done2}), 64'd0);

`ifdef LEVINSON_STAB_CHECK_EN
        // ---- ORDER=4, unstable k on iteration 1 ----
        st4 = 1'b1;
        tick(); c = 1; st4 = 1'b0;
        cnt_a = 0;
        while (!done4 && c < 60) begin
            if (iter4 == 4'd1) kun4 = 1'b1;
            if (kl4) cnt_a++;
            tick(); c++;
        end
        kun4 = 1'b0;
        chk("t6_done_cycle", 64'(c), 64'd11);
        chk("t6_err_iter", 64'({err4, iter4}), 64'b1_0001);
        chk("t6_k_loads", 64'(cnt_a), 64'd1);
        tick();
        chk("t6_err_hold", 64'({err4, busy4}), 64'b10);
        st4 = 1'b1;
        tick(); c = 1; st4 = 1'b0;
        chk("t6_err_clear", 64'({err4, busy4}), 64'b01);
        while (!done4 && c < 200) begin
            tick(); c++;
        end
        chk("t6_rerun_done", 64'({err4, 8'(c)}), 64'd40);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
